// File: rtl/softmax_feeder.sv
// softmax_feeder: collects a frame of logits, then replays it to the softmax core with Start/Datain timing
module softmax_feeder #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 3,
  parameter int TIMEOUT = 1024
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              InValid,
  output logic              InReady,
  input  logic [DATA_W-1:0] InData,
  input  logic              InLast,
  output logic              Start,
  output logic [DATA_W-1:0] Datain,
  output logic [CNT_W-1:0]  N,
  input  logic              Done,
  output logic              Busy,
  output logic              Drop,
  output logic              Timeout
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {COLLECT, START, STREAM, WAIT_DONE} state_t;
  state_t              state_q;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   data_q;
  logic [CNT_W-1:0]    cnt_q, idx_q, n_q, idx_nxt;
  logic [WW-1:0]       wd_q;
  logic                ready_q, start_q, busy_q, drop_q, timeout_q;
  logic                xfer, room;
  assign InReady = ready_q;
  assign Start   = start_q;
  assign Datain  = data_q;
  assign N       = n_q;
  assign Busy    = busy_q;
  assign Drop    = drop_q;
  assign Timeout = timeout_q;
  // Transfer qualification, room check and the next replay index.
  always_comb begin
    xfer    = InValid & ready_q & (state_q == COLLECT);
    room    = cnt_q < CNT_W'(DEPTH);
    idx_nxt = idx_q + 1'b1;
  end
  // Frame buffer: contents need no reset, only words that fit are written.
  always_ff @(posedge Clock) begin
    if (xfer && room) mem_q[cnt_q[IW-1:0]] <= InData;
  end
  // Sequencer: collect, pulse Start, replay one word per cycle, then wait for Done or the watchdog.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q   <= COLLECT;
      data_q    <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      n_q       <= '0;
      wd_q      <= '0;
      ready_q   <= 1'b1;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      drop_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      start_q   <= 1'b0;
      drop_q    <= 1'b0;
      timeout_q <= 1'b0;
      case (state_q)
        COLLECT: if (xfer) begin
          if (room) cnt_q <= cnt_q + 1'b1;
          else drop_q <= 1'b1;
          if (InLast) begin
            n_q     <= room ? cnt_q : cnt_q - 1'b1;
            state_q <= START;
            start_q <= 1'b1;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          data_q  <= mem_q[0];
          idx_q   <= '0;
          state_q <= STREAM;
        end
        STREAM: if (idx_q == n_q) begin
          state_q <= WAIT_DONE;
          wd_q    <= '0;
        end else begin
          idx_q  <= idx_nxt;
          data_q <= mem_q[idx_nxt[IW-1:0]];
        end
        WAIT_DONE: if (Done || wd_q == WW'(TIMEOUT - 1)) begin
          timeout_q <= !Done;
          state_q   <= COLLECT;
          cnt_q     <= '0;
          wd_q      <= '0;
          ready_q   <= 1'b1;
          busy_q    <= 1'b0;
        end else begin
          wd_q <= wd_q + 1'b1;
        end
        default: state_q <= COLLECT;
      endcase
    end
  end
endmodule

// File: tb/tb_softmax_feeder.sv
// tb_softmax_feeder: directed frames against hand-computed Start/Datain/N timing
module tb_softmax_feeder;
  logic        Clock, Reset, InValid, InReady, InLast, Start, Done, Busy, Drop, Timeout;
  logic [31:0] InData, Datain;
  logic [2:0]  N;
  logic [31:0] ew [4];
  int          n_chk = 0;
  int          n_fail = 0;

  softmax_feeder #(.DATA_W(32), .DEPTH(4), .CNT_W(3), .TIMEOUT(16)) dut (
    .Clock(Clock), .Reset(Reset), .InValid(InValid), .InReady(InReady), .InData(InData),
    .InLast(InLast), .Start(Start), .Datain(Datain), .N(N), .Done(Done), .Busy(Busy),
    .Drop(Drop), .Timeout(Timeout)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge Clock);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic last);
    InValid = 1'b1;
    InData  = d;
    InLast  = last;
    step;
    InValid = 1'b0;
    InLast  = 1'b0;
    InData  = 32'hDEADBEEF;
  endtask

  // Called in the Start cycle; checks the replay of ew[0..n] and the WAIT_DONE hold.
  task automatic stream_chk(input int n, input bit do_done);
    check("start_pulse", Start, 1);
    check("n_value", N, n);
    check("busy_start", Busy, 1);
    check("ready_low", InReady, 0);
    for (int k = 0; k <= n; k++) begin
      step;
      check($sformatf("datain_%0d", k), Datain, ew[k]);
      check("start_once", Start, 0);
    end
    step;
    check("datain_hold", Datain, ew[n]);
    check("busy_wait", Busy, 1);
    check("n_hold", N, n);
    if (do_done) begin
      Done = 1'b1;
      step;
      Done = 1'b0;
      check("ready_after_done", InReady, 1);
      check("busy_after_done", Busy, 0);
    end
  endtask

  initial begin
    int  c;
    bit  seen;
    Reset = 1'b0; InValid = 1'b0; InData = '0; InLast = 1'b0; Done = 1'b0;
    step;
    step;
    check("rst_ready", InReady, 1);
    check("rst_start", Start, 0);
    check("rst_datain", Datain, 0);
    check("rst_n", N, 0);
    check("rst_busy", Busy, 0);
    check("rst_drop", Drop, 0);
    check("rst_timeout", Timeout, 0);
    Reset = 1'b1;
    step;
    // T1: full four-word frame
    ew = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
    send(ew[0], 0); send(ew[1], 0); send(ew[2], 0); send(ew[3], 1);
    stream_chk(3, 1);
    // T2: single word frame
    ew[0] = 32'h3F800000;
    send(ew[0], 1);
    stream_chk(0, 1);
    // T3: six words, last two dropped
    ew = '{32'hA0000001, 32'hA0000002, 32'hA0000003, 32'hA0000004};
    send(ew[0], 0); send(ew[1], 0); send(ew[2], 0); send(ew[3], 0);
    check("no_drop_4", Drop, 0);
    send(32'hA0000005, 0);
    check("drop_5", Drop, 1);
    send(32'hA0000006, 1);
    check("drop_6", Drop, 1);
    stream_chk(3, 1);
    check("drop_done", Drop, 0);
    // T4: watchdog release with no Done
    ew[0] = 32'h11111111; ew[1] = 32'h22222222;
    send(ew[0], 0); send(ew[1], 1);
    stream_chk(1, 0);
    c = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step;
      c++;
      if (Timeout) seen = 1'b1;
    end
    check("timeout_seen", seen, 1);
    check("timeout_cycles", c, 16);
    check("timeout_ready", InReady, 1);
    check("timeout_busy", Busy, 0);
    step;
    check("timeout_pulse", Timeout, 0);
    // T5: gapped valid with spurious Done in COLLECT
    ew = '{32'h0000C001, 32'h0000C002, 32'h0000C003, 32'h00000000};
    Done = 1'b1;
    step;
    Done = 1'b0;
    check("done_ignored", Busy, 0);
    send(ew[0], 0);
    Done = 1'b1; InData = 32'hBAD00001; InLast = 1'b1;
    step;
    Done = 1'b0; InLast = 1'b0;
    send(ew[1], 0);
    InData = 32'hBAD00002;
    step;
    send(ew[2], 1);
    stream_chk(2, 1);
    // T6: async reset during STREAM, then a clean frame
    ew = '{32'h50000001, 32'h50000002, 32'h50000003, 32'h50000004};
    send(ew[0], 0); send(ew[1], 0); send(ew[2], 0); send(ew[3], 1);
    step;
    step;
    check("pre_rst_datain", Datain, ew[1]);
    Reset = 1'b0;
    #1;
    check("arst_datain", Datain, 0);
    check("arst_n", N, 0);
    check("arst_busy", Busy, 0);
    check("arst_ready", InReady, 1);
    check("arst_start", Start, 0);
    @(posedge Clock);
    #1;
    Reset = 1'b1;
    step;
    check("post_rst_start", Start, 0);
    check("post_rst_busy", Busy, 0);
    ew[0] = 32'h60000001; ew[1] = 32'h60000002;
    send(ew[0], 0); send(ew[1], 1);
    stream_chk(1, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
